// File: rtl/and_lab_pkg.sv
// Shared constants for the AND-gate lab input stage: board and simulation debounce settings.
package and_lab_pkg;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 50000;
  localparam int unsigned SIM_STABLE_CYCLES     = 4;
  localparam int unsigned DEFAULT_CNT_W         = 16;

endpackage : and_lab_pkg

// File: rtl/debounce_ch.sv
// One debounce channel: two-flop synchroniser, stability counter, registered level and edge pulses.
module debounce_ch
  import and_lab_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Synchroniser chain; s2 is the only copy the rest of the channel looks at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Stable when s2 matches the output; otherwise count, committing on the last count.
  always_comb begin
    cnt_d  = '0;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q != out_q) begin
      if (cnt_q == LAST_CNT) begin
        out_d  = s2_q;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule : debounce_ch

// File: rtl/and_in_debounce.sv
// Two independent debounced inputs feeding the a/b pins of the AND gate stage.
module and_in_debounce
  import and_lab_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_o,
  output logic b_o,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_ch #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_ch_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (a_raw),
    .out_o (a_o),
    .rise_o(a_rise),
    .fall_o(a_fall)
  );

  debounce_ch #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_ch_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (b_raw),
    .out_o (b_o),
    .rise_o(b_rise),
    .fall_o(b_fall)
  );

endmodule : and_in_debounce

// File: tb/tb_and_in_debounce.sv
// Directed bench for and_in_debounce at STABLE_CYCLES=4, CNT_W=3.
module tb_and_in_debounce;
  import and_lab_pkg::*;

  logic clk, rst_n, a_raw, b_raw;
  logic a_o, b_o, a_rise, a_fall, b_rise, b_fall;

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";
  logic  exp_a   = 1'b0;
  logic  exp_b   = 1'b0;

  and_in_debounce #(
    .STABLE_CYCLES(SIM_STABLE_CYCLES),
    .CNT_W        (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a_o   (a_o),
    .b_o   (b_o),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %b expected %b at %0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input logic ar, input logic af, input logic br, input logic bf);
    check("a_o", a_o, exp_a);
    check("b_o", b_o, exp_b);
    check("a_rise", a_rise, ar);
    check("a_fall", a_fall, af);
    check("b_rise", b_rise, br);
    check("b_fall", b_fall, bf);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit i of a mask marks edge i (counted from 1) as the edge where that output toggles.
  task automatic seq(input int n, input logic [15:0] a_tog, input logic [15:0] b_tog);
    logic ar, af, br, bf;
    for (int i = 1; i <= n; i++) begin
      tick();
      ar = 1'b0; af = 1'b0; br = 1'b0; bf = 1'b0;
      if (a_tog[i]) begin
        exp_a = ~exp_a;
        ar = exp_a;
        af = ~exp_a;
      end
      if (b_tog[i]) begin
        exp_b = ~exp_b;
        br = exp_b;
        bf = ~exp_b;
      end
      chk_all(ar, af, br, bf);
    end
  endtask

  localparam logic [15:0] E2 = 16'h0004;
  localparam logic [15:0] E6 = 16'h0040;

  initial begin
    rst_n = 1'b1;
    a_raw = 1'b1;
    b_raw = 1'b1;
    #1 rst_n = 1'b0;

    phase = "reset";
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all(1'b0, 1'b0, 1'b0, 1'b0);
    end

    phase = "clean_press";
    a_raw = 1'b0;
    b_raw = 1'b0;
    rst_n = 1'b1;
    a_raw = 1'b1;
    seq(7, E6, 16'h0);

    phase = "release_a";
    a_raw = 1'b0;
    seq(7, E6, 16'h0);

    phase = "bounce";
    for (int i = 0; i < 8; i++) begin
      a_raw = (i % 2 == 0);
      tick();
      chk_all(1'b0, 1'b0, 1'b0, 1'b0);
    end
    a_raw = 1'b0;
    seq(3, 16'h0, 16'h0);
    phase = "bounce_settle";
    a_raw = 1'b1;
    seq(6, E6, 16'h0);

    phase = "press_b";
    b_raw = 1'b1;
    seq(7, 16'h0, E6);

    phase = "drop_both";
    a_raw = 1'b0;
    b_raw = 1'b0;
    seq(7, E6, E6);

    phase = "near_miss4";
    a_raw = 1'b1;
    seq(4, 16'h0, 16'h0);
    a_raw = 1'b0;
    seq(6, E2 | E6, 16'h0);

    phase = "short3";
    a_raw = 1'b1;
    seq(3, 16'h0, 16'h0);
    a_raw = 1'b0;
    seq(6, 16'h0, 16'h0);

    phase = "pre_reset_b";
    b_raw = 1'b1;
    seq(7, 16'h0, E6);
    a_raw = 1'b1;
    seq(4, 16'h0, 16'h0);

    phase = "async_reset";
    #3 rst_n = 1'b0;
    exp_a = 1'b0;
    exp_b = 1'b0;
    #1 chk_all(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all(1'b0, 1'b0, 1'b0, 1'b0);
    end

    phase = "after_reset";
    rst_n = 1'b1;
    seq(7, E6, E6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_and_in_debounce
